pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
- Receiving end for fixed-length pulses from the team's pulse generators.
- Measures how long an incoming level pulse stays high, counted in clock-enable ticks.
- Hands the result to a consumer through a valid/ack register interface, with overflow and lost-result flags.
- Sits beside the generators in test and loopback paths so that a generated length L reads back as L.

Parameters:
- WIDTH, 16, width of the counter and of the reported pulse width; saturation value is 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- ce  input  1  count enable; a tick counts only when ce=1.
- pin  input  1  pulse input, already synchronous to clk.
- ack  input  1  consumer accepts the current result (sampled at clk).
- width  output  WIDTH  measured pulse width of the held result.
- valid  output  1  result held and not yet acknowledged.
- ovf  output  1  held result saturated; true width is at least 2^WIDTH-1.
- overrun  output  1  at least one completed pulse was dropped while valid was pending.
- busy  output  1  measurement in progress (state != IDLE).

Behaviour:
- Reset (rst=1 at clk):
  - state=IDLE; cnt, width=0; valid, ovf, overrun=0.
  - pind<=1, so a pulse already high when reset is released is ignored and never produces a partial result.
- Edge detect:
  - pind is a registered copy of pin.
  - rise = pin & !pind; fall = !pin & pind; both combinational and valid in the same cycle.
- States: IDLE, MEAS, SAT.
  - IDLE: on rise, cnt<=ce?1:0 and go to MEAS. Otherwise hold.
  - MEAS, while pin=1 and ce=1:
    - if cnt==2^WIDTH-1, go to SAT with cnt held;
    - else cnt<=cnt+1.
  - MEAS, on fall: no increment that cycle; issue result {cnt, ovf=0}; go to IDLE.
  - SAT: cnt is frozen. On fall, issue result {2^WIDTH-1, ovf=1} and go to IDLE.
- Width rule: the result is the number of clk cycles with pin=1 and ce=1, from the rise cycle up to the cycle before fall.
  - With ce tied to 1, a pulse high for L cycles reports width=L.
  - A pulse with no ce tick reports width=0, and valid is still asserted.
- A rise in the same cycle as a fall is impossible, since pin is one bit. A new rise on the cycle after a fall starts a fresh measurement normally.
- Result handshake (all registered):
  - Result issued while valid=0: load width/ovf; valid<=1 on the next edge, i.e. valid rises 1 clk after the fall cycle.
  - ack while valid=1: valid<=0 and overrun<=0.
  - Result issued in the same cycle as an accepted ack: load the new result, valid stays 1, overrun<=0.
  - Result issued while valid=1 and ack=0: drop the new result, keep the held width/ovf, and set overrun<=1. Set takes priority over any clear in that cycle.
  - ack while valid=0: ignored.
- Outputs are registered and glitch-free regardless of the ce pattern.
- Reset mid-measurement: abandons the measurement and clears the held result; no valid pulse is produced.

Decomposition:
- Shared include, pulse_defs: state encodings (IDLE=2'd0, MEAS=2'd1, SAT=2'd2) and the saturation constant expression. Both are reused by the generator bench and the checker.
- One sub-module: pulse_edge_det, a registered delay with reset-to-1 that produces rise/fall. It is reusable by the generators' start edge logic.
- Counter, FSM and result register stay in pulse_width_meter.

Test Plan:
- ce=1, WIDTH=4: pin high 5 cycles -> valid rises 1 clk after fall, width=5, ovf=0, overrun=0; ack clears valid next edge.
- ce pulsing 1-of-8 cycles, WIDTH=4: pin high 40 cycles aligned to start on a ce tick -> width=5.
- WIDTH=4, ce=1: pin high 20 cycles -> busy throughout, state SAT after 15 counts, width=15, ovf=1.
- Two pulses (3 then 7 cycles) with no ack -> width=3, overrun=1. Then ack -> valid=0, overrun=0. Then a pulse of 4 plus ack in the same cycle as its issue -> width=4, valid stays 1.
- pin held high through reset release, falls after 6 cycles -> no result, valid=0. A following 2-cycle pulse -> width=2.
- rst asserted for 1 clk mid-pulse (3 counts in) while valid=1 -> valid=0, width=0, busy=0. The remainder of that pulse is ignored (pind=1 after reset).

Source files
------------

// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the pulse width meter and its companions:
// FSM state encodings and the width of the state debug view.
package pulse_width_meter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    SAT  = 2'd2
  } pwm_state_e;

  // All-ones value of a counter of the given width, i.e. its saturation point.
  function automatic logic [31:0] sat_value(input int unsigned w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Registered one-cycle delay of a synchronous level with rise/fall strobes.
// Resets to 1 so a level already high at reset release never looks like a rise.
module pulse_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic pind_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pind_q <= 1'b1;
    end else begin
      pind_q <= pin_i;
    end
  end

  assign rise_o = pin_i & ~pind_q;
  assign fall_o = ~pin_i & pind_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures how many ce ticks a level pulse stays high and holds the result
// behind a valid/ack register interface with saturation and overrun flags.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               pin,
  input  logic               ack,
  output logic [WIDTH-1:0]   width,
  output logic               valid,
  output logic               ovf,
  output logic               overrun,
  output logic               busy,
  output logic [STATE_W-1:0] state_dbg
);

  // Handshake: valid stays high from result load until the cycle ack is
  // sampled high; a result arriving in that same cycle replaces the held one.
  localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(sat_value(WIDTH));

  pwm_state_e       state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] width_q;
  logic             valid_q;
  logic             ovf_q;
  logic             overrun_q;

  logic             rise;
  logic             fall;
  logic             res_vld_d;
  logic [WIDTH-1:0] res_width_d;
  logic             res_ovf_d;

  pulse_edge_det u_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .pin_i  (pin),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    res_vld_d   = 1'b0;
    res_width_d = cnt_q;
    res_ovf_d   = 1'b0;
    if (fall && state_q == MEAS) begin
      res_vld_d = 1'b1;
    end else if (fall && state_q == SAT) begin
      res_vld_d   = 1'b1;
      res_width_d = SAT_VAL;
      res_ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_q   <= {{(WIDTH-1){1'b0}}, ce};
            state_q <= MEAS;
          end
        end
        MEAS: begin
          // The fall cycle itself is low, so it never adds a count.
          if (fall) begin
            state_q <= IDLE;
          end else if (pin && ce) begin
            if (cnt_q == SAT_VAL) begin
              state_q <= SAT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SAT: begin
          if (fall) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (res_vld_d) begin
        if (!valid_q || ack) begin
          width_q   <= res_width_d;
          ovf_q     <= res_ovf_d;
          valid_q   <= 1'b1;
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign width     = width_q;
  assign valid     = valid_q;
  assign ovf       = ovf_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter (WIDTH=4): expected results are queued
// as pulses are driven and a negedge monitor pops them as the DUT presents them.
module tb_pulse_width_meter;
  import pulse_width_meter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce  = 1'b1;
  logic         pin = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] width;
  logic         valid;
  logic         ovf;
  logic         overrun;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Each entry is {ovf, width}.
  logic [W:0] exp_q[$];

  pulse_width_meter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pin       (pin),
    .ack       (ack),
    .width     (width),
    .valid     (valid),
    .ovf       (ovf),
    .overrun   (overrun),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want summary");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin high for len cycles; ce ticks on every period-th cycle (0 = never).
  // Ends after the fall cycle has been clocked, optionally acking in it.
  task automatic pulse(input int len, input int period, input logic ack_at_fall);
    pin = 1'b1;
    for (int i = 0; i < len; i++) begin
      ce = (period != 0) && ((i % period) == 0);
      step();
    end
    ce  = 1'b1;
    pin = 1'b0;
    ack = ack_at_fall;
    step();
    ack = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic expect_res(input int w, input logic o);
    exp_q.push_back({o, W'(w)});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic valid_prev = 1'b0;
  logic ack_prev   = 1'b0;

  always @(negedge clk) begin
    logic [W:0] e;
    if (valid === 1'b1 && (!valid_prev || ack_prev)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got width=%0d ovf=%0d, want none", width, ovf);
      end else begin
        e = exp_q.pop_front();
        if ({ovf, width} !== e) begin
          n_err++;
          $display("FAIL result: got width=%0d ovf=%0d, want width=%0d ovf=%0d",
                   width, ovf, e[W-1:0], e[W]);
        end
      end
    end
    valid_prev = (valid === 1'b1);
    ack_prev   = ack;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    check("reset_width", 32'(width), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_busy", 32'(busy), 0);
    step(2);

    // Basic 5-cycle pulse with ce=1.
    expect_res(5, 1'b0);
    pulse(5, 1, 1'b0);
    check("t1_valid", 32'(valid), 1);
    check("t1_overrun", 32'(overrun), 0);
    do_ack();
    check("t1_ack_clears", 32'(valid), 0);
    step(2);

    // ce one tick in eight over a 40-cycle pulse.
    expect_res(5, 1'b0);
    pulse(40, 8, 1'b0);
    do_ack();
    step(2);

    // No ce tick at all still yields a zero-width result.
    expect_res(0, 1'b0);
    pulse(4, 0, 1'b0);
    do_ack();
    step(2);

    // Saturation: 20 cycles at ce=1.
    pin = 1'b1;
    step();
    check("t3_busy", 32'(busy), 1);
    step(14);
    check("t3_meas_at_15", 32'(state_dbg), 32'(MEAS));
    step();
    check("t3_sat_at_16", 32'(state_dbg), 32'(SAT));
    step(4);
    check("t3_busy_sat", 32'(busy), 1);
    expect_res(15, 1'b1);
    pin = 1'b0;
    step();
    check("t3_idle", 32'(busy), 0);
    do_ack();
    step(2);

    // Saturation boundary: 15 fits, 16 saturates.
    expect_res(15, 1'b0);
    pulse(15, 1, 1'b0);
    do_ack();
    expect_res(15, 1'b1);
    pulse(16, 1, 1'b0);
    do_ack();
    step(2);

    // Overrun: second pulse starts right after the first one's fall.
    expect_res(3, 1'b0);
    pulse(3, 1, 1'b0);
    pulse(7, 1, 1'b0);
    check("t4_overrun", 32'(overrun), 1);
    check("t4_width_kept", 32'(width), 3);
    check("t4_valid_kept", 32'(valid), 1);
    do_ack();
    check("t4_ack_valid", 32'(valid), 0);
    check("t4_ack_overrun", 32'(overrun), 0);
    step(2);

    // New result accepted in the same cycle as ack keeps valid high.
    expect_res(2, 1'b0);
    pulse(2, 1, 1'b0);
    expect_res(4, 1'b0);
    pulse(4, 1, 1'b1);
    check("t4_reload_valid", 32'(valid), 1);
    check("t4_reload_width", 32'(width), 4);
    check("t4_reload_overrun", 32'(overrun), 0);
    do_ack();
    step(2);

    // Pin high across reset release is ignored.
    rst = 1'b1;
    pin = 1'b1;
    step(2);
    rst = 1'b0;
    step(6);
    pin = 1'b0;
    step(2);
    check("t5_no_result", 32'(valid), 0);
    check("t5_not_busy", 32'(busy), 0);
    expect_res(2, 1'b0);
    pulse(2, 1, 1'b0);
    check("t5_width", 32'(width), 2);
    do_ack();
    step(2);

    // Reset mid-pulse while a result is held.
    expect_res(3, 1'b0);
    pulse(3, 1, 1'b0);
    pin = 1'b1;
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", 32'(valid), 0);
    check("t6_width", 32'(width), 0);
    check("t6_busy", 32'(busy), 0);
    step(4);
    pin = 1'b0;
    step(3);
    check("t6_tail_valid", 32'(valid), 0);
    check("t6_tail_busy", 32'(busy), 0);

    step(3);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
